// File: rtl/lcd_id_reader.sv
// rtl/lcd_id_reader.sv - power-up RGB LCD strap reader and panel ID decoder
// Optional feature macro: LCD_ID_RESCAN_EN (adds the rescan input).
// sys_rst is asserted asynchronously; its release is expected to already be
// synchronous to sys_clk, so edge 1 is the first sys_clk edge after release.
module lcd_id_reader #(
  parameter int SETTLE_CYCLES = 50000,
  parameter int SAMPLE_GAP    = 1000,
  parameter int SAMPLE_NUM    = 4,
  parameter int MAX_RETRY     = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
`ifdef LCD_ID_RESCAN_EN
  input  logic        rescan,
`endif
  input  logic [23:0] lcd_rgb_in,
  output logic        lcd_rgb_oe,
  output logic [15:0] lcd_id,
  output logic        id_valid,
  output logic        id_err
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int GW = $clog2(SAMPLE_GAP + 1);
  localparam int NW = $clog2(SAMPLE_NUM + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(SAMPLE_GAP - 1);
  localparam logic [NW-1:0] NUM_TOTAL   = NW'(SAMPLE_NUM);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  localparam logic [2:0] ST_SETTLE = 3'd0;
  localparam logic [2:0] ST_SAMPLE = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_FAIL   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [NW-1:0] num_q, num_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [2:0]    code_q, code_d;
  logic          oe_q, oe_d;
  logic [15:0]   id_q, id_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic [2:0]    strap;
  logic          rescan_req;
  logic          map_ok;
  logic [15:0]   map_id;
  logic          unused_pads;

  // Straps M2/M1/M0 live on the MSB of each colour byte.
  assign strap       = {lcd_rgb_in[23], lcd_rgb_in[15], lcd_rgb_in[7]};
  assign unused_pads = ^{lcd_rgb_in[22:16], lcd_rgb_in[14:8], lcd_rgb_in[6:0]};

`ifdef LCD_ID_RESCAN_EN
  assign rescan_req = rescan;
`else
  assign rescan_req = 1'b0;
`endif

  // Strap code to panel ID lookup; unsupported codes are flagged, not mapped.
  always_comb begin
    map_ok = 1'b1;
    map_id = 16'h0000;
    case (code_q)
      3'b000:  map_id = 16'h4342;
      3'b001:  map_id = 16'h7084;
      3'b010:  map_id = 16'h7016;
      3'b100:  map_id = 16'h4384;
      3'b101:  map_id = 16'h1018;
      default: map_ok = 1'b0;
    endcase
  end

  // Detection sequencer: settle, sample and compare, decode, then hold.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    gap_d    = gap_q;
    num_d    = num_q;
    retry_d  = retry_q;
    code_d   = code_q;
    oe_d     = oe_q;
    id_d     = id_q;
    valid_d  = valid_q;
    err_d    = err_q;
    case (state_q)
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          // This edge is the first sample of the round.
          settle_d = '0;
          gap_d    = '0;
          num_d    = NW'(1);
          code_d   = strap;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_SAMPLE: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (strap != code_q) begin
            // Disagreement ends the round at once.
            num_d   = '0;
            retry_d = retry_q + RW'(1);
            if (retry_q + RW'(1) >= RETRY_LIMIT) begin
              state_d = ST_FAIL;
              err_d   = 1'b1;
            end else begin
              state_d = ST_SETTLE;
            end
          end else if (num_q + NW'(1) == NUM_TOTAL) begin
            num_d   = '0;
            state_d = ST_DECODE;
          end else begin
            num_d = num_q + NW'(1);
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      ST_DECODE: begin
        if (map_ok) begin
          state_d = ST_DONE;
          id_d    = map_id;
          valid_d = 1'b1;
          oe_d    = 1'b1;
        end else begin
          state_d = ST_FAIL;
          err_d   = 1'b1;
        end
      end
      ST_DONE, ST_FAIL: begin
        // Terminal; only a rescan request restarts detection.
        if (rescan_req) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
          gap_d    = '0;
          num_d    = '0;
          retry_d  = '0;
          oe_d     = 1'b0;
          id_d     = 16'h0000;
          valid_d  = 1'b0;
          err_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_SETTLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by sys_rst.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= ST_SETTLE;
      settle_q <= '0;
      gap_q    <= '0;
      num_q    <= '0;
      retry_q  <= '0;
      code_q   <= 3'b000;
      oe_q     <= 1'b0;
      id_q     <= 16'h0000;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      gap_q    <= gap_d;
      num_q    <= num_d;
      retry_q  <= retry_d;
      code_q   <= code_d;
      oe_q     <= oe_d;
      id_q     <= id_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign lcd_rgb_oe = oe_q;
  assign lcd_id     = id_q;
  assign id_valid   = valid_q;
  assign id_err     = err_q;

endmodule

// File: tb/tb_lcd_id_reader.sv
// tb/tb_lcd_id_reader.sv - self-checking bench for lcd_id_reader
module tb_lcd_id_reader;
  localparam int SC = 16;
  localparam int SG = 4;
  localparam int SN = 4;
  localparam int MR = 3;
  localparam int PL = 200;
  localparam logic [18:0] ERR_V = {3'b100, 16'h0000};

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [23:0] lcd_rgb_in = 24'h0;
  logic        lcd_rgb_oe;
  logic [15:0] lcd_id;
  logic        id_valid;
  logic        id_err;
`ifdef LCD_ID_RESCAN_EN
  logic        rescan = 1'b0;
`endif

  lcd_id_reader #(
    .SETTLE_CYCLES(SC), .SAMPLE_GAP(SG), .SAMPLE_NUM(SN), .MAX_RETRY(MR)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
`ifdef LCD_ID_RESCAN_EN
    .rescan(rescan),
`endif
    .lcd_rgb_in(lcd_rgb_in),
    .lcd_rgb_oe(lcd_rgb_oe),
    .lcd_id(lcd_id),
    .id_valid(id_valid),
    .id_err(id_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [2:0]  code;
    logic [18:0] exp;
  } vec_t;

  vec_t        tbl[8];
  logic [2:0]  pat[PL];
  logic [15:0] idmap[8];
  bit          okmap[8];
  int          total = 0;
  int          bad = 0;

  function automatic logic [23:0] pads(input logic [2:0] c);
    logic [23:0] v;
    v = 24'($urandom);
    v[23] = c[2];
    v[15] = c[1];
    v[7]  = c[0];
    return v;
  endfunction

  function automatic logic [18:0] outs();
    return {id_err, id_valid, lcd_rgb_oe, lcd_id};
  endfunction

  function automatic logic [18:0] done_v(input logic [15:0] id);
    return {3'b011, id};
  endfunction

  task automatic check(input string name, input int e, input logic [18:0] act, input logic [18:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s edge %0d: got {err,valid,oe,id}=%h required %h", name, e, act, exp);
    end
  endtask

  // Reset for `hold` edges, release, play pat[] and check every edge.
  task automatic run_pat(input string name, input int hold, input int exp_edge,
                         input logic [18:0] fv, input int tail);
    sys_rst = 1'b1;
    repeat (hold) @(posedge sys_clk);
    #1 check({name, "_rst"}, 0, outs(), 19'h0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    lcd_rgb_in = pads(pat[1]);
    for (int e = 1; e <= exp_edge + tail; e++) begin
      @(posedge sys_clk);
      #1 check(name, e, outs(), (e >= exp_edge) ? fv : 19'h0);
      if (e + 1 < PL) lcd_rgb_in = pads(pat[e + 1]);
    end
  endtask

  // Reference: walk the sample instants round by round.
  task automatic model(output int ev, output logic [18:0] fv);
    int start, fails, first, e;
    bit mis;
    start = 0;
    fails = 0;
    ev = 0;
    fv = 19'h0;
    e = 0;
    forever begin
      first = start + SC;
      mis = 1'b0;
      for (int n = 1; n < SN; n++) begin
        e = first + n * SG;
        if (pat[e] != pat[first]) begin
          mis = 1'b1;
          break;
        end
      end
      if (mis) begin
        fails++;
        if (fails >= MR) begin
          ev = e;
          fv = ERR_V;
          return;
        end
        start = e;
      end else begin
        ev = first + (SN - 1) * SG + 1;
        fv = okmap[pat[first]] ? done_v(idmap[pat[first]]) : ERR_V;
        return;
      end
    end
  endtask

  task automatic fill(input logic [2:0] c);
    for (int i = 0; i < PL; i++) pat[i] = c;
  endtask

  initial begin
    int ev;
    logic [18:0] fv;
    logic [2:0] base, alt;
    int sw;

    for (int i = 0; i < 8; i++) begin
      idmap[i] = 16'h0000;
      okmap[i] = 1'b0;
    end
    idmap[0] = 16'h4342; okmap[0] = 1'b1;
    idmap[1] = 16'h7084; okmap[1] = 1'b1;
    idmap[2] = 16'h7016; okmap[2] = 1'b1;
    idmap[4] = 16'h4384; okmap[4] = 1'b1;
    idmap[5] = 16'h1018; okmap[5] = 1'b1;

    tbl[0] = '{3'b001, {3'b011, 16'h7084}};
    tbl[1] = '{3'b000, {3'b011, 16'h4342}};
    tbl[2] = '{3'b010, {3'b011, 16'h7016}};
    tbl[3] = '{3'b100, {3'b011, 16'h4384}};
    tbl[4] = '{3'b101, {3'b011, 16'h1018}};
    tbl[5] = '{3'b011, ERR_V};
    tbl[6] = '{3'b110, ERR_V};
    tbl[7] = '{3'b111, ERR_V};

    // Stable straps: result lands at edge 29.
    for (int i = 0; i < 8; i++) begin
      fill(tbl[i].code);
      run_pat($sformatf("table_%b", tbl[i].code), 2, 29, tbl[i].exp, 3);
    end

    // M0 glitch covering sample 3 of round 1, then stable 000.
    fill(3'b000);
    for (int e = 21; e <= 24; e++) pat[e] = 3'b001;
    run_pat("retry_once", 2, 53, {3'b011, 16'h4342}, 3);

    // M0 toggling every 3 cycles: third failed round at edge 64.
    for (int e = 0; e < PL; e++) pat[e] = {2'b00, 1'(((e / 3) % 2))};
    run_pat("toggle", 2, 64, ERR_V, 12);

    // Asynchronous clear from DONE, between clock edges.
    fill(3'b001);
    run_pat("pre_async", 2, 29, {3'b011, 16'h7084}, 1);
    #2 sys_rst = 1'b1;
    #1 check("async_clear", 0, outs(), 19'h0);
    sys_rst = 1'b0;

    // Reset at edge 20 mid-SAMPLE, held 5 cycles, then a clean detection.
    fill(3'b001);
    @(negedge sys_clk);
    lcd_rgb_in = pads(3'b001);
    for (int e = 1; e <= 20; e++) begin
      @(posedge sys_clk);
      #1;
    end
    sys_rst = 1'b1;
    #1 check("mid_rst", 20, outs(), 19'h0);
    run_pat("after_mid_rst", 5, 29, {3'b011, 16'h7084}, 3);

    // Randomised strap streams against the round-by-round model.
    for (int t = 0; t < 40; t++) begin
      base = 3'($urandom_range(0, 7));
      alt  = 3'($urandom_range(0, 7));
      sw   = (t % 3 == 0) ? int'($urandom_range(10, 60)) : PL;
      for (int e = 0; e < PL; e++) begin
        pat[e] = (e < sw) ? base : alt;
        if ($urandom_range(0, 24) == 0) pat[e] = pat[e] ^ 3'(1 << $urandom_range(0, 2));
      end
      model(ev, fv);
      run_pat("random", 2, ev, fv, 4);
    end

`ifdef LCD_ID_RESCAN_EN
    // Rescan from DONE with new straps.
    fill(3'b001);
    run_pat("pre_rescan", 2, 29, {3'b011, 16'h7084}, 2);
    lcd_rgb_in = pads(3'b100);
    rescan = 1'b1;
    @(posedge sys_clk);
    #1 rescan = 1'b0;
    check("rescan_drop", 0, outs(), 19'h0);
    for (int k = 1; k <= 31; k++) begin
      lcd_rgb_in = pads(3'b100);
      @(posedge sys_clk);
      #1 check("rescan", k, outs(), (k >= 29) ? {3'b011, 16'h4384} : 19'h0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_id_reader.md
Name: lcd_id_reader

Overview:
- Power-up identification of the attached RGB LCD panel.
- Holds the panel RGB bus released (tri-state), waits for pull-ups/pull-downs to settle, then samples the strap pins M2/M1/M0 on lcd_rgb_in[23]/[15]/[7] repeatedly.
- Decodes the strap code into the 16-bit lcd_id consumed by the pixel-clock divider and the timing generator.
- Sits between the LCD top-level pad logic and the clock/timing blocks.

Parameters:
SETTLE_CYCLES, 50000, sys_clk cycles from reset release to first sample (1 ms at 50 MHz); minimum 2.
SAMPLE_GAP, 1000, sys_clk cycles between consecutive samples; minimum 1.
SAMPLE_NUM, 4, number of samples that must all agree; range 2..15.
MAX_RETRY, 3, failed agreement rounds before declaring error; range 1..15.

Ports:
sys_clk  input  1  system clock
sys_rst  input  1  asynchronous reset, active-high
lcd_rgb_in  input  24  RGB pad input values (already synchronised at the pads)
lcd_rgb_oe  output  1  1 = RGB pads may be driven by the display path; 0 = pads released
lcd_id  output  16  decoded panel ID; 16'h0000 until a valid ID is known
id_valid  output  1  level; lcd_id holds a supported ID
id_err  output  1  level; detection failed (unstable straps or unsupported code)

Behaviour:
- Reset (async assert, sync release): state SETTLE, all counters 0, lcd_rgb_oe=0, lcd_id=16'h0000, id_valid=0, id_err=0.
- Straps: code = {lcd_rgb_in[23], lcd_rgb_in[15], lcd_rgb_in[7]} = {M2,M1,M0}.
- FSM states:
  - SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: take the first sample on entry. Take each further sample SAMPLE_GAP cycles after the previous one, for SAMPLE_NUM samples total. Compare every sample with the first.
  - DECODE: one cycle.
  - DONE: terminal state.
  - FAIL: terminal state.
- Timing: sample 1 is taken at rising edge number SETTLE_CYCLES after reset release. Sample n is taken at edge SETTLE_CYCLES+(n-1)*SAMPLE_GAP.
- Mismatch:
  - Any sample differing from sample 1 aborts the round immediately and increments the retry count.
  - If retries < MAX_RETRY: return to SETTLE with counters cleared.
  - Otherwise: go to FAIL.
- DECODE mapping:
  - 3'b000 -> 16'h4342
  - 3'b001 -> 16'h7084
  - 3'b010 -> 16'h7016
  - 3'b100 -> 16'h4384
  - 3'b101 -> 16'h1018
  - any other code -> FAIL
- Entering DONE (registered, same edge): lcd_id=mapped value, id_valid=1, lcd_rgb_oe=1.
- Latency with no retries: id_valid rises at edge SETTLE_CYCLES+(SAMPLE_NUM-1)*SAMPLE_GAP+1.
- Entering FAIL: lcd_id=16'h0000, id_err=1, id_valid=0, lcd_rgb_oe=0. The divider's default case then gates pclk low.
- Output exclusivity: id_valid and id_err are never both 1. lcd_id is nonzero only while id_valid=1.
- DONE/FAIL: outputs hold indefinitely; pad changes are ignored. Exit only by reset (or rescan, see below).
- Reset mid-operation: outputs clear immediately (asynchronously); retry count clears.
- Counter widths: sized by $clog2 of each parameter; no wrap occurs within legal ranges.

Optional Feature:
- Macro: LCD_ID_RESCAN_EN.
- Defined:
  - Adds input port rescan (1 bit, single-cycle pulse).
  - A pulse in DONE or FAIL forces, on the next edge: lcd_rgb_oe=0, id_valid=0, id_err=0, lcd_id=16'h0000, retry count cleared, state SETTLE.
  - A pulse in SETTLE/SAMPLE/DECODE is ignored.
  - A rescan coinciding with sys_rst: reset wins.
- Undefined: no rescan port; detection is one-shot per reset.

Test Plan:
- SETTLE_CYCLES=16, SAMPLE_GAP=4, SAMPLE_NUM=4; straps M2..M0=3'b001 held stable -> id_valid rises at edge 29 after reset release; lcd_id=16'h7084; lcd_rgb_oe=1; id_err=0.
- Same params; each strap code 000/010/100/101 -> lcd_id 4342/7016/4384/1018 respectively, all at edge 29.
- Strap 3'b011 stable -> id_err=1 at edge 29; lcd_id=0; id_valid=0; lcd_rgb_oe=0.
- M0 toggles between samples 2 and 3 in round 1 only, then stable 3'b000 -> one retry; id_valid rises later than edge 29 with lcd_id=16'h4342.
- MAX_RETRY=3; M0 toggling every 3 cycles forever -> id_err=1 after the third failed round; id_valid never asserts.
- sys_rst asserted at edge 20 (mid-SAMPLE), released 5 cycles later -> all outputs 0 during reset; id_valid rises at edge 29 after the new release.
- With LCD_ID_RESCAN_EN: after DONE with ID 7084, change straps to 3'b100 and pulse rescan -> id_valid drops on the next edge; returns with lcd_id=16'h4384 29 edges after the pulse edge.
